// File: rtl/ram_lsu_bridge_if.sv
// Core-side load/store handshake plus RAM-side request/response bus of the LSU bridge.
// The bridge connects through the slave modport; the core/RAM environment uses master.
interface ram_lsu_bridge_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic        req_we_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic [3:0]  ram_sel_o;
  logic        ram_we_o;
  logic [31:0] ram_data_i;
  logic        ram_req_valid_o;
  logic        ram_req_ready_i;
  logic        ram_rsp_valid_i;
  logic        ram_rsp_ready_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i, req_we_i,
    input  rsp_ready_i, ram_data_i, ram_req_ready_i, ram_rsp_valid_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output ram_addr_o, ram_data_o, ram_sel_o, ram_we_o, ram_req_valid_o, ram_rsp_ready_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i, req_we_i,
    output rsp_ready_i, ram_data_i, ram_req_ready_i, ram_rsp_valid_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  ram_addr_o, ram_data_o, ram_sel_o, ram_we_o, ram_req_valid_o, ram_rsp_ready_o
  );
endinterface

// File: rtl/ram_lsu_bridge.sv
// Load/store bridge to the data RAM: one access in flight, response 3 cycles after accept with a zero-wait RAM.
// Faulting accesses bypass the RAM; core response is held in DONE/ERR until rsp_ready_i.
module ram_lsu_bridge #(
  parameter int DP     = 4096,
  parameter int ADDR_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  ram_lsu_bridge_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        we_q, we_d;

  logic        fault;
  logic [31:0] word_idx;
  logic [1:0]  off;
  logic [3:0]  sel;
  logic [31:0] wdata_rep;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Only the low ADDR_W bits are decoded by the RAM, so the range check ignores the rest.
  assign word_idx = 32'(bus.req_addr_i[ADDR_W-1:2]);

  always_comb begin
    fault = 1'b0;
    case (bus.req_size_i)
      2'd1:    fault = bus.req_addr_i[0];
      2'd2:    fault = |bus.req_addr_i[1:0];
      2'd3:    fault = 1'b1;
      default: fault = 1'b0;
    endcase
    if (word_idx >= 32'(DP)) fault = 1'b1;
  end

  assign off = addr_q[1:0];

  always_comb begin
    sel       = 4'b1111;
    wdata_rep = wdata_q;
    case (size_q)
      2'd0: begin
        sel       = 4'b0001 << off;
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        sel       = off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        sel       = 4'b1111;
        wdata_rep = wdata_q;
      end
    endcase
  end

  always_comb begin
    ld_byte = bus.ram_data_i[7:0];
    case (off)
      2'd1:    ld_byte = bus.ram_data_i[15:8];
      2'd2:    ld_byte = bus.ram_data_i[23:16];
      2'd3:    ld_byte = bus.ram_data_i[31:24];
      default: ld_byte = bus.ram_data_i[7:0];
    endcase
    ld_half = off[1] ? bus.ram_data_i[31:16] : bus.ram_data_i[15:0];
    case (size_q)
      2'd0:    ld_data = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'd1:    ld_data = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = bus.ram_data_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    we_d    = we_q;

    bus.req_ready_o     = 1'b0;
    bus.rsp_valid_o     = 1'b0;
    bus.rsp_rdata_o     = 32'd0;
    bus.rsp_err_o       = 1'b0;
    bus.ram_addr_o      = 32'd0;
    bus.ram_data_o      = 32'd0;
    bus.ram_sel_o       = 4'd0;
    bus.ram_we_o        = 1'b0;
    bus.ram_req_valid_o = 1'b0;
    bus.ram_rsp_ready_o = 1'b0;

    case (state_q)
      IDLE: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) begin
          addr_d  = bus.req_addr_i;
          wdata_d = bus.req_wdata_i;
          size_d  = bus.req_size_i;
          uns_d   = bus.req_unsigned_i;
          we_d    = bus.req_we_i;
          rdata_d = 32'd0;
          state_d = fault ? ERR : ISSUE;
        end
      end
      ISSUE: begin
        bus.ram_req_valid_o = 1'b1;
        bus.ram_addr_o      = {addr_q[31:2], 2'b00};
        bus.ram_data_o      = wdata_rep;
        bus.ram_sel_o       = sel;
        bus.ram_we_o        = we_q;
        if (bus.ram_req_ready_i) state_d = WAIT;
      end
      WAIT: begin
        bus.ram_rsp_ready_o = 1'b1;
        if (bus.ram_rsp_valid_i) begin
          rdata_d = we_q ? 32'd0 : ld_data;
          state_d = DONE;
        end
      end
      DONE: begin
        bus.rsp_valid_o = 1'b1;
        bus.rsp_rdata_o = rdata_q;
        if (bus.rsp_ready_i) state_d = IDLE;
      end
      ERR: begin
        bus.rsp_valid_o = 1'b1;
        bus.rsp_err_o   = 1'b1;
        if (bus.rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
    end
  end

endmodule

// File: tb/tb_ram_lsu_bridge.sv
// Directed bench for ram_lsu_bridge: a word-array RAM model answers requests and a
// scoreboard queue holds the expected core response of every accepted access.
module tb_ram_lsu_bridge;
  localparam int DP = 4096;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  logic [32:0] sb_q[$];
  logic [31:0] mem [64];

  ram_lsu_bridge_if bus ();

  ram_lsu_bridge #(.DP(DP), .ADDR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ":req_ready"},     32'(bus.req_ready_o), 32'd1);
    chk({tag, ":rsp_valid"},     32'(bus.rsp_valid_o), 32'd0);
    chk({tag, ":rsp_err"},       32'(bus.rsp_err_o), 32'd0);
    chk({tag, ":rsp_rdata"},     bus.rsp_rdata_o, 32'd0);
    chk({tag, ":ram_addr"},      bus.ram_addr_o, 32'd0);
    chk({tag, ":ram_data"},      bus.ram_data_o, 32'd0);
    chk({tag, ":ram_sel"},       32'(bus.ram_sel_o), 32'd0);
    chk({tag, ":ram_we"},        32'(bus.ram_we_o), 32'd0);
    chk({tag, ":ram_req_valid"}, 32'(bus.ram_req_valid_o), 32'd0);
    chk({tag, ":ram_rsp_ready"}, 32'(bus.ram_rsp_ready_o), 32'd0);
  endtask

  // One complete access. Called right after a clock edge with the bridge idle.
  task automatic access(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input logic we,
                        input bit exp_err, input logic [31:0] exp_rdata,
                        input logic [3:0] exp_sel, input logic [31:0] exp_wd,
                        input int ram_stall, input int rsp_stall);
    int cyc;
    logic [32:0] sb;
    chk({tag, ":req_ready_idle"}, 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i    = 1'b1;
    bus.req_addr_i     = addr;
    bus.req_wdata_i    = wdata;
    bus.req_size_i     = size;
    bus.req_unsigned_i = uns;
    bus.req_we_i       = we;
    sb_q.push_back({exp_err, exp_rdata});
    step();
    bus.req_valid_i = 1'b0;
    cyc = 1;
    if (!exp_err) begin
      for (int i = 0; i <= ram_stall; i++) begin
        chk({tag, ":ram_req_valid"}, 32'(bus.ram_req_valid_o), 32'd1);
        chk({tag, ":ram_addr"},      bus.ram_addr_o, {addr[31:2], 2'b00});
        chk({tag, ":ram_sel"},       32'(bus.ram_sel_o), 32'(exp_sel));
        chk({tag, ":ram_data"},      bus.ram_data_o, exp_wd);
        chk({tag, ":ram_we"},        32'(bus.ram_we_o), 32'(we));
        chk({tag, ":ram_rsp_ready_issue"}, 32'(bus.ram_rsp_ready_o), 32'd0);
        chk({tag, ":req_ready_busy"}, 32'(bus.req_ready_o), 32'd0);
        bus.ram_req_ready_i = (i == ram_stall);
        // A stray RAM response while still issuing must be ignored.
        bus.ram_rsp_valid_i = (i != ram_stall);
        bus.ram_data_i      = 32'hA5A5_A5A5;
        step();
        cyc++;
      end
      bus.ram_req_ready_i = 1'b0;
      bus.ram_rsp_valid_i = 1'b0;
      chk({tag, ":ram_rsp_ready_wait"}, 32'(bus.ram_rsp_ready_o), 32'd1);
      chk({tag, ":ram_req_valid_wait"}, 32'(bus.ram_req_valid_o), 32'd0);
      bus.ram_data_i      = mem[addr[7:2]];
      bus.ram_rsp_valid_i = 1'b1;
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (exp_sel[b]) mem[addr[7:2]][8*b +: 8] = exp_wd[8*b +: 8];
      end
      step();
      cyc++;
      bus.ram_rsp_valid_i = 1'b0;
      bus.ram_data_i      = 32'h5A5A_5A5A;
    end
    while (!bus.rsp_valid_o && cyc < 20) begin
      if (exp_err) chk({tag, ":ram_req_valid_err"}, 32'(bus.ram_req_valid_o), 32'd0);
      step();
      cyc++;
    end
    chk({tag, ":latency"}, 32'(cyc), exp_err ? 32'd1 : 32'(3 + ram_stall));
    if (exp_err) chk({tag, ":ram_req_valid_err"}, 32'(bus.ram_req_valid_o), 32'd0);
    for (int i = 0; i < rsp_stall; i++) begin
      bus.req_valid_i = 1'b1;
      bus.req_addr_i  = 32'h0000_0020;
      bus.req_size_i  = 2'd2;
      chk({tag, ":rsp_valid_hold"}, 32'(bus.rsp_valid_o), 32'd1);
      chk({tag, ":rsp_rdata_hold"}, bus.rsp_rdata_o, exp_rdata);
      chk({tag, ":req_ready_hold"}, 32'(bus.req_ready_o), 32'd0);
      step();
    end
    bus.req_valid_i = 1'b0;
    chk({tag, ":rsp_valid"}, 32'(bus.rsp_valid_o), 32'd1);
    if (sb_q.size() == 0) begin
      chk({tag, ":sb_empty"}, 32'd1, 32'd0);
    end else begin
      sb = sb_q.pop_front();
      chk({tag, ":rsp_err"},   32'(bus.rsp_err_o), 32'(sb[32]));
      chk({tag, ":rsp_rdata"}, bus.rsp_rdata_o, sb[31:0]);
    end
    bus.rsp_ready_i = 1'b1;
    step();
    bus.rsp_ready_i = 1'b0;
    chk({tag, ":rsp_valid_after"}, 32'(bus.rsp_valid_o), 32'd0);
    chk({tag, ":req_ready_after"}, 32'(bus.req_ready_o), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    rst_n              = 1'b0;
    bus.req_valid_i    = 1'b0;
    bus.req_addr_i     = 32'd0;
    bus.req_wdata_i    = 32'd0;
    bus.req_size_i     = 2'd0;
    bus.req_unsigned_i = 1'b0;
    bus.req_we_i       = 1'b0;
    bus.rsp_ready_i    = 1'b0;
    bus.ram_data_i     = 32'd0;
    bus.ram_req_ready_i = 1'b0;
    bus.ram_rsp_valid_i = 1'b0;
    #1;
    chk_reset_outputs("reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    chk_reset_outputs("post_reset");

    access("st_word", 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0, 4'b1111, 32'hDEADBEEF, 0, 0);
    access("ld_word", 32'h10, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 4'b1111, 32'h0, 0, 0);

    mem[4] = 32'h1122_3344;
    access("st_byte", 32'h13, 32'h0000_0080, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0, 4'b1000, 32'h8080_8080, 0, 0);
    access("ld_byte_s", 32'h13, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FF80, 4'b1000, 32'h0, 0, 0);
    access("ld_byte_u", 32'h13, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0080, 4'b1000, 32'h0, 0, 0);
    access("ld_byte_u1", 32'h11, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0033, 4'b0010, 32'h0, 0, 0);

    mem[4] = 32'h8001_7FFF;
    access("ld_half_hi", 32'h12, 32'h0, 2'd1, 1'b0, 1'b0, 1'b0, 32'hFFFF_8001, 4'b1100, 32'h0, 0, 0);
    access("ld_half_lo", 32'h10, 32'h0, 2'd1, 1'b0, 1'b0, 1'b0, 32'h0000_7FFF, 4'b0011, 32'h0, 0, 0);
    access("st_half", 32'h12, 32'h1234_ABCD, 2'd1, 1'b0, 1'b1, 1'b0, 32'h0, 4'b1100, 32'hABCD_ABCD, 0, 0);

    access("err_half", 32'h11, 32'h0, 2'd1, 1'b0, 1'b0, 1'b1, 32'h0, 4'b0, 32'h0, 0, 0);
    access("err_word", 32'h16, 32'h0, 2'd2, 1'b0, 1'b1, 1'b1, 32'h0, 4'b0, 32'h0, 0, 2);
    access("err_size", 32'h10, 32'h0, 2'd3, 1'b0, 1'b0, 1'b1, 32'h0, 4'b0, 32'h0, 0, 0);
    access("err_range", 32'(4 * DP), 32'h0, 2'd2, 1'b0, 1'b0, 1'b1, 32'h0, 4'b0, 32'h0, 0, 0);

    access("stall_ld", 32'h10, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0, 32'hABCD_7FFF, 4'b1111, 32'h0, 3, 5);

    // Abort an access in WAIT with an asynchronous reset.
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h10;
    bus.req_size_i  = 2'd2;
    bus.req_we_i    = 1'b0;
    step();
    bus.req_valid_i     = 1'b0;
    bus.ram_req_ready_i = 1'b1;
    step();
    bus.ram_req_ready_i = 1'b0;
    chk("abort:in_wait", 32'(bus.ram_rsp_ready_o), 32'd1);
    #1;
    rst_n               = 1'b0;
    bus.ram_rsp_valid_i = 1'b1;
    bus.ram_data_i      = 32'h0BAD_0BAD;
    #1;
    chk_reset_outputs("abort_async");
    step();
    step();
    bus.ram_rsp_valid_i = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("abort:no_rsp", 32'(bus.rsp_valid_o), 32'd0);
      step();
    end
    access("ld_after_abort", 32'h10, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0, 32'hABCD_7FFF, 4'b1111, 32'h0, 0, 0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ram_lsu_bridge.md
Name: ram_lsu_bridge

Overview:
- Sits directly upstream of the on-chip data RAM.
- Accepts core load/store requests with size, sign and byte address, and produces the word-aligned address, byte-lane select, lane-replicated write data and valid/ready request the RAM consumes.
- On the RAM response it extracts and sign- or zero-extends load data and returns it to the core.
- Misaligned, illegal-size and out-of-range accesses never reach the RAM; they complete with an error response.
- One access outstanding at a time.

Parameters:
- DP, 4096: RAM depth in 32-bit words; the word index addr[ADDR_W-1:2] must be < DP.
- ADDR_W, 16: number of low address bits decoded by the RAM (byte offset width).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  bridge can accept a request
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-aligned
- req_size_i  in  2  access size: 0 byte, 1 half, 2 word, 3 illegal
- req_unsigned_i  in  1  load zero-extend (1) / sign-extend (0)
- req_we_i  in  1  1 store, 0 load
- rsp_valid_o  out  1  core response valid
- rsp_ready_i  in  1  core accepts response
- rsp_rdata_o  out  32  formatted load data; 0 for stores and errors
- rsp_err_o  out  1  access faulted; qualified by rsp_valid_o
- ram_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
- ram_data_o  out  32  lane-replicated write data
- ram_sel_o  out  4  byte-lane select
- ram_we_o  out  1  write enable
- ram_data_i  in  32  RAM read data
- ram_req_valid_o  out  1  request to RAM
- ram_req_ready_i  in  1  RAM accepts request
- ram_rsp_valid_i  in  1  RAM response valid
- ram_rsp_ready_o  out  1  bridge accepts RAM response

Behaviour:
Reset and state machine
- Reset is asynchronous and active-low.
- During and after reset: state IDLE, all captured registers 0.
- Output reset values: req_ready_o=1; every other output is 0 (rsp_valid_o, rsp_err_o, rsp_rdata_o, ram_* outputs, ram_rsp_ready_o).
- States are IDLE, ISSUE, WAIT, DONE, ERR.

IDLE
- req_ready_o=1.
- On req_valid_i, capture addr, wdata, size, unsigned and we.
- Fault check:
  - size==3, or
  - size==1 with addr[0]=1, or
  - size==2 with addr[1:0]!=0, or
  - addr[ADDR_W-1:2] >= DP.
- If the fault check is true, go to ERR; otherwise go to ISSUE.

ISSUE
- ram_req_valid_o=1. ram_addr_o, ram_data_o, ram_sel_o and ram_we_o are driven from registers and are stable while valid is high.
- On ram_req_ready_i, go to WAIT.

WAIT
- ram_rsp_ready_o=1.
- On ram_rsp_valid_i, register the formatted ram_data_i (loads) or 0 (stores), then go to DONE.

DONE / ERR
- rsp_valid_o=1. rsp_err_o=0 in DONE, 1 in ERR; rsp_rdata_o=0 in ERR.
- rsp_valid_o and rsp_rdata_o stay stable until rsp_ready_i.
- On rsp_ready_i, go to IDLE.
- The next request is accepted no earlier than the following cycle (no same-cycle turnaround).

Lane and data rules (off = addr[1:0])
- sel:
  - byte: 4'b0001<<off
  - half: off[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
  - sel is generated identically for loads.
- Write data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load data:
  - byte: lane ram_data_i[8*off+:8]
  - half: ram_data_i[16*off[1]+:16]
  - Extended to 32 bits by req_unsigned.
  - word: passed unchanged.

Latency and ordering
- Request accepted at cycle 0; ram_req_valid_o at cycle 1.
- With ram ready at cycle 1 and RAM response at cycle 2, rsp_valid_o is asserted at cycle 3.
- Minimum 4-cycle issue-to-issue interval.
- Stores wait for the RAM response before completing.
- Core backpressure (rsp_ready_i low) holds the block in DONE/ERR indefinitely; no further requests are accepted meanwhile.

Boundary conditions
- ram_rsp_valid_i outside WAIT is ignored (ram_rsp_ready_o=0).
- Reset mid-transaction aborts it immediately: returns to IDLE, drops any pending RAM request or response and emits no core response.

Test Plan:
- Word store addr 0x0000_0010, data 0xDEADBEEF, then word load same addr -> ram_sel_o=4'b1111, ram_addr_o=0x10; load rsp_rdata_o=0xDEADBEEF, rsp_err_o=0, rsp_valid_o at cycle 3 with zero-wait RAM.
- Byte store 0x80 to addr 0x13 over word 0x11223344, then signed byte load 0x13 -> sel 4'b1000, ram_data_o=0x80808080; rsp_rdata_o=0xFFFFFF80. Unsigned load of the same byte -> 0x00000080.
- Half load addr 0x12 of word 0x8001_7FFF, signed -> 0xFFFF8001. Same access at addr 0x10 -> 0x00007FFF.
- Misaligned half at 0x11, word at 0x16, size=3, and word addr 4*DP -> rsp_err_o=1, rsp_rdata_o=0, ram_req_valid_o never asserted.
- Stall case: ram_req_ready_i low 3 cycles and rsp_ready_i low 5 cycles -> RAM request fields and core response are stable throughout; req_ready_o=0 until the handshake completes.
- Reset asserted in WAIT -> all outputs at reset values asynchronously. After release, a new word load completes normally and the aborted access produces no response.
